finger_count_converter: RTL and testbench
=========================================

// Module: finger_count_converter
// PURPOSE
//   Converts a 5-bit hand-state vector (one bit per raised finger) into
//   two 4-bit numbers under two counting schemes.
//   Scheme 1 gives the number of raised fingers. Scheme 2 decodes a
//   gesture table covering 0-9 and flags patterns outside the table.
//   Sits between the gesture/sensor front end and the display/decoder
//   logic. Outputs are registered; latency is one cycle.
// PARAMETERS
//   INVALID_CODE  4'hF  value driven on n2 when hs is not a scheme-2 gesture
// PORTS
//   clk       in   1  system clock, rising-edge
//   rst_n     in   1  asynchronous, active-low reset
//   in_valid  in   1  hs is sampled on this cycle
//   hs        in   5  hand state; [4]=thumb [3]=index [2]=middle [1]=ring [0]=pinky; 1=raised
//   out_valid out  1  n1/n2/n2_err hold a fresh result
//   n1        out  4  scheme-1 result (0..5)
//   n2        out  4  scheme-2 result (0..9, or INVALID_CODE)
//   n2_err    out  1  hs was not a legal scheme-2 gesture
// BEHAVIOUR
//   - Single clock domain, clk. rst_n is async assert, sync deassert
//     (external synchroniser). Reset values: out_valid=0, n1=0, n2=0,
//     n2_err=0.
//   - Rising clk with in_valid=1: register n1, n2 and n2_err from hs,
//     and set out_valid=1 on the same edge (1-cycle latency).
//   - Rising clk with in_valid=0: set out_valid=0. n1, n2 and n2_err
//     hold their last values.
//   - n1 = popcount(hs), zero-extended to 4 bits. All 32 codes are
//     legal; max 5.
//   - n2 table, hs binary -> n2:
//       00000->0  01000->1  01100->2  01110->3  01111->4
//       11111->5  10000->6  11000->7  11100->8  11110->9
//   - Every other hs code (22 codes) -> n2=INVALID_CODE and n2_err=1.
//     n1 still follows popcount for these codes.
//   - n2_err=0 whenever hs is in the table.
//   - Both schemes are computed from the same sampled hs on the same
//     edge; no dependency between n1 and n2.
//   - Back-to-back in_valid: one result per cycle, no stalls, no
//     backpressure.
//   - Reset asserted mid-stream: outputs clear immediately (async).
//     The first in_valid after release yields a normal result on the
//     next edge.
//   - Combinational decode is purely a function of hs. No internal
//     state beyond the output registers.
// TESTING
//   - Reset: rst_n=0 with hs=11111, in_valid=1 -> out_valid=0, n1=0,
//     n2=0, n2_err=0 while rst_n low.
//   - Exhaustive sweep: hs=0..31, in_valid=1, one per cycle.
//     Check each result one cycle later:
//       hs=00000 -> n1=0, n2=0;   hs=11111 -> n1=5, n2=5;
//       hs=10000 -> n1=1, n2=6;   hs=11110 -> n1=4, n2=9.
//   - Invalid gestures: hs=00001 -> n1=1, n2=4'hF, n2_err=1;
//     hs=10101 -> n1=3, n2=4'hF, n2_err=1.
//   - Hold: apply hs=01100 with in_valid=1, then in_valid=0 with
//     hs=11111 -> out_valid drops to 0; n1=2, n2=2 are held.
//   - Async reset mid-stream: assert rst_n low between edges during
//     the sweep -> outputs clear without waiting for clk. After
//     release, hs=01111 -> n1=4, n2=4.
//   - Parameter override: INVALID_CODE=4'hE, hs=00011 -> n2=4'hE,
//     n2_err=1.

Source files
------------

// File: rtl/finger_count_converter.sv
// Converts a 5-bit hand-state vector into a raised-finger count (scheme 1)
// and a decoded gesture digit 0-9 with an error flag (scheme 2), registered.
module finger_count_converter #(
    parameter logic [3:0] INVALID_CODE = 4'hF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [4:0] hs,
    output logic       out_valid,
    output logic [3:0] n1,
    output logic [3:0] n2,
    output logic       n2_err
);

    logic [3:0] w_popcount;
    logic [3:0] w_gesture;
    logic       w_gesture_err;

    logic       r_out_valid;
    logic [3:0] r_n1;
    logic [3:0] r_n2;
    logic       r_n2_err;

    always_comb begin
        w_popcount = 4'd0;
        for (int i = 0; i < 5; i++) begin
            w_popcount = w_popcount + {3'b000, hs[i]};
        end
    end

    // Bit order is thumb..pinky; 0-4 raise fingers from the index side,
    // 5 is the open hand, 6-9 raise from the thumb side.
    always_comb begin
        w_gesture     = INVALID_CODE;
        w_gesture_err = 1'b0;
        unique case (hs)
            5'b00000: w_gesture = 4'd0;
            5'b01000: w_gesture = 4'd1;
            5'b01100: w_gesture = 4'd2;
            5'b01110: w_gesture = 4'd3;
            5'b01111: w_gesture = 4'd4;
            5'b11111: w_gesture = 4'd5;
            5'b10000: w_gesture = 4'd6;
            5'b11000: w_gesture = 4'd7;
            5'b11100: w_gesture = 4'd8;
            5'b11110: w_gesture = 4'd9;
            default: begin
                w_gesture     = INVALID_CODE;
                w_gesture_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_n1        <= 4'd0;
            r_n2        <= 4'd0;
            r_n2_err    <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            // Results hold across idle cycles; only out_valid drops.
            if (in_valid) begin
                r_n1     <= w_popcount;
                r_n2     <= w_gesture;
                r_n2_err <= w_gesture_err;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign n1        = r_n1;
    assign n2        = r_n2;
    assign n2_err    = r_n2_err;

endmodule

// File: tb/tb_finger_count_converter.sv
// Directed bench for finger_count_converter: reset, full hs sweep, invalid
// gestures, hold, async reset mid-stream and INVALID_CODE override.
module tb_finger_count_converter;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [4:0] hs;

    logic       out_valid,  b_out_valid;
    logic [3:0] n1,         b_n1;
    logic [3:0] n2,         b_n2;
    logic       n2_err,     b_n2_err;

    int errors = 0;
    int checks = 0;

    logic [3:0] exp_n1 [32];
    logic [3:0] exp_n2 [32];

    finger_count_converter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .hs        (hs),
        .out_valid (out_valid),
        .n1        (n1),
        .n2        (n2),
        .n2_err    (n2_err)
    );

    finger_count_converter #(.INVALID_CODE(4'hE)) dut_e (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .hs        (hs),
        .out_valid (b_out_valid),
        .n1        (b_n1),
        .n2        (b_n2),
        .n2_err    (b_n2_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after a rising edge; outputs are read 1ns after the next.
    task automatic step(input logic v, input logic [4:0] h);
        in_valid = v;
        hs       = h;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        hs       = 5'b11111;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || n1 !== 4'd0 || n2 !== 4'd0 || n2_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: got v=%b n1=%0d n2=%h err=%b, want 0/0/0/0", out_valid, n1, n2, n2_err);
        end
        checks++;
        if (b_out_valid !== 1'b0 || b_n1 !== 4'd0 || b_n2 !== 4'd0 || b_n2_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_e: got v=%b n1=%0d n2=%h err=%b, want 0/0/0/0", b_out_valid, b_n1, b_n2, b_n2_err);
        end
        rst_n = 1'b1;
        step(1'b0, 5'b00000);
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 32; i++) begin
            step(1'b1, i[4:0]);
            $display("sweep hs=%b -> v=%b n1=%0d n2=%h err=%b", i[4:0], out_valid, n1, n2, n2_err);
            checks++;
            if (out_valid !== 1'b1 || n1 !== exp_n1[i] || n2 !== exp_n2[i]
                || n2_err !== (exp_n2[i] == 4'hF)) begin
                errors++;
                $display("FAIL sweep hs=%b: got v=%b n1=%0d n2=%h err=%b, want 1/%0d/%h/%b",
                         i[4:0], out_valid, n1, n2, n2_err, exp_n1[i], exp_n2[i], exp_n2[i] == 4'hF);
            end
        end
    endtask

    task automatic test_invalid();
        step(1'b1, 5'b00001);
        checks++;
        if (n1 !== 4'd1 || n2 !== 4'hF || n2_err !== 1'b1) begin
            errors++;
            $display("FAIL invalid_00001: got n1=%0d n2=%h err=%b, want 1/f/1", n1, n2, n2_err);
        end
        step(1'b1, 5'b10101);
        checks++;
        if (n1 !== 4'd3 || n2 !== 4'hF || n2_err !== 1'b1) begin
            errors++;
            $display("FAIL invalid_10101: got n1=%0d n2=%h err=%b, want 3/f/1", n1, n2, n2_err);
        end
        step(1'b1, 5'b11110);
        checks++;
        if (n1 !== 4'd4 || n2 !== 4'd9 || n2_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clears: got n1=%0d n2=%h err=%b, want 4/9/0", n1, n2, n2_err);
        end
    endtask

    task automatic test_hold();
        step(1'b1, 5'b01100);
        checks++;
        if (out_valid !== 1'b1 || n1 !== 4'd2 || n2 !== 4'd2 || n2_err !== 1'b0) begin
            errors++;
            $display("FAIL hold_load: got v=%b n1=%0d n2=%h err=%b, want 1/2/2/0", out_valid, n1, n2, n2_err);
        end
        step(1'b0, 5'b11111);
        checks++;
        if (out_valid !== 1'b0 || n1 !== 4'd2 || n2 !== 4'd2 || n2_err !== 1'b0) begin
            errors++;
            $display("FAIL hold_idle: got v=%b n1=%0d n2=%h err=%b, want 0/2/2/0", out_valid, n1, n2, n2_err);
        end
        step(1'b0, 5'b00001);
        checks++;
        if (out_valid !== 1'b0 || n1 !== 4'd2 || n2 !== 4'd2) begin
            errors++;
            $display("FAIL hold_idle2: got v=%b n1=%0d n2=%h, want 0/2/2", out_valid, n1, n2);
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 5'b11111);
        step(1'b1, 5'b11100);
        checks++;
        if (out_valid !== 1'b1 || n1 !== 4'd3 || n2 !== 4'd8) begin
            errors++;
            $display("FAIL pre_reset: got v=%b n1=%0d n2=%h, want 1/3/8", out_valid, n1, n2);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || n1 !== 4'd0 || n2 !== 4'd0 || n2_err !== 1'b0) begin
            errors++;
            $display("FAIL async_clear: got v=%b n1=%0d n2=%h err=%b, want 0/0/0/0", out_valid, n1, n2, n2_err);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 5'b01111);
        checks++;
        if (out_valid !== 1'b1 || n1 !== 4'd4 || n2 !== 4'd4 || n2_err !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: got v=%b n1=%0d n2=%h err=%b, want 1/4/4/0", out_valid, n1, n2, n2_err);
        end
    endtask

    task automatic test_param_override();
        step(1'b1, 5'b00011);
        checks++;
        if (b_n2 !== 4'hE || b_n2_err !== 1'b1 || b_n1 !== 4'd2) begin
            errors++;
            $display("FAIL override: got n1=%0d n2=%h err=%b, want 2/e/1", b_n1, b_n2, b_n2_err);
        end
        checks++;
        if (n2 !== 4'hF || n2_err !== 1'b1) begin
            errors++;
            $display("FAIL default_code: got n2=%h err=%b, want f/1", n2, n2_err);
        end
        step(1'b1, 5'b11000);
        checks++;
        if (b_n2 !== 4'd7 || b_n2_err !== 1'b0) begin
            errors++;
            $display("FAIL override_legal: got n2=%h err=%b, want 7/0", b_n2, b_n2_err);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 5'b00000);
        checks++;
        if (out_valid !== 1'b1 || n2 !== 4'd0) begin
            errors++;
            $display("FAIL b2b_0: got v=%b n2=%h, want 1/0", out_valid, n2);
        end
        step(1'b1, 5'b01000);
        checks++;
        if (out_valid !== 1'b1 || n1 !== 4'd1 || n2 !== 4'd1) begin
            errors++;
            $display("FAIL b2b_1: got v=%b n1=%0d n2=%h, want 1/1/1", out_valid, n1, n2);
        end
        step(1'b1, 5'b01110);
        checks++;
        if (out_valid !== 1'b1 || n1 !== 4'd3 || n2 !== 4'd3) begin
            errors++;
            $display("FAIL b2b_3: got v=%b n1=%0d n2=%h, want 1/3/3", out_valid, n1, n2);
        end
        step(1'b0, 5'b00000);
    endtask

    initial begin
        exp_n1 = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd1, 4'd2, 4'd2, 4'd3,
                   4'd1, 4'd2, 4'd2, 4'd3, 4'd2, 4'd3, 4'd3, 4'd4,
                   4'd1, 4'd2, 4'd2, 4'd3, 4'd2, 4'd3, 4'd3, 4'd4,
                   4'd2, 4'd3, 4'd3, 4'd4, 4'd3, 4'd4, 4'd4, 4'd5};
        exp_n2 = '{4'd0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
                   4'd1, 4'hF, 4'hF, 4'hF, 4'd2, 4'hF, 4'd3, 4'd4,
                   4'd6, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
                   4'd7, 4'hF, 4'hF, 4'hF, 4'd8, 4'hF, 4'd9, 4'd5};
        rst_n    = 1'b0;
        in_valid = 1'b0;
        hs       = 5'b00000;
        #1;
        test_reset();
        test_sweep();
        test_invalid();
        test_hold();
        test_async_reset();
        test_param_override();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
